// File: rtl/lb_diverge_monitor.sv
// Lockstep load-buffer divergence monitor: after arm, settles, then compares both core copies over a fixed window.
// Optional build macro LB_DIVERGE_DATA_CMP_EN also flags data mismatches when both valids are high.
module lb_diverge_monitor #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WINDOW_CYCLES = 12,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             lb_valid1,
  input  logic             lb_valid2,
  input  logic [31:0]      lb_addr1,
  input  logic [31:0]      lb_addr2,
  input  logic [31:0]      lb_data1,
  input  logic [31:0]      lb_data2,
  output logic             busy,
  output logic             done,
  output logic             diverge,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [31:0]      fail_addr1,
  output logic [31:0]      fail_addr2,
  output logic [CNT_W-1:0] event_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WATCH  = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : CNT_ZERO;
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam state_t           ARM_STATE   = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_WATCH;

  function automatic logic ctl_mismatch(input logic v1, input logic v2,
                                        input logic [31:0] a1, input logic [31:0] a2);
    return (v1 ^ v2) | (v1 & v2 & (a1 != a2));
  endfunction

  state_t           state_r, nxt_state_s;
  logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
  logic             busy_r, nxt_busy_s;
  logic             done_r, nxt_done_s;
  logic             diverge_r, nxt_diverge_s;
  logic [CNT_W-1:0] fail_cycle_r, nxt_fail_cycle_s;
  logic [31:0]      fail_addr1_r, nxt_fail_addr1_s;
  logic [31:0]      fail_addr2_r, nxt_fail_addr2_s;
  logic [CNT_W-1:0] event_cnt_r, nxt_event_cnt_s;
  logic             data_div_s;
  logic             div_s;

`ifdef LB_DIVERGE_DATA_CMP_EN
  assign data_div_s = lb_valid1 & lb_valid2 & (lb_data1 != lb_data2);
`else
  logic unused_data_s;
  assign unused_data_s = ^{lb_data1, lb_data2};
  assign data_div_s    = 1'b0;
`endif

  assign div_s = ctl_mismatch(lb_valid1, lb_valid2, lb_addr1, lb_addr2) | data_div_s;

  // Next-state, counter and capture logic; arm overrides everything in the current cycle.
  always_comb begin
    nxt_state_s      = state_r;
    nxt_cnt_s        = cnt_r;
    nxt_diverge_s    = diverge_r;
    nxt_fail_cycle_s = fail_cycle_r;
    nxt_fail_addr1_s = fail_addr1_r;
    nxt_fail_addr2_s = fail_addr2_r;
    nxt_event_cnt_s  = event_cnt_r;
    if (arm) begin
      nxt_state_s      = ARM_STATE;
      nxt_cnt_s        = CNT_ZERO;
      nxt_diverge_s    = 1'b0;
      nxt_fail_cycle_s = CNT_ZERO;
      nxt_fail_addr1_s = 32'h0000_0000;
      nxt_fail_addr2_s = 32'h0000_0000;
      nxt_event_cnt_s  = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: nxt_state_s = ST_IDLE;
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            nxt_state_s = ST_WATCH;
            nxt_cnt_s   = CNT_ZERO;
          end else begin
            nxt_cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WATCH: begin
          if (div_s) begin
            if (!diverge_r) begin
              nxt_diverge_s    = 1'b1;
              nxt_fail_cycle_s = cnt_r;
              nxt_fail_addr1_s = lb_addr1;
              nxt_fail_addr2_s = lb_addr2;
            end else begin
              nxt_diverge_s = diverge_r;
            end
            if (event_cnt_r != CNT_MAX) begin
              nxt_event_cnt_s = event_cnt_r + CNT_ONE;
            end else begin
              nxt_event_cnt_s = event_cnt_r;
            end
          end else begin
            nxt_event_cnt_s = event_cnt_r;
          end
          // A divergence on the final window cycle must still steer to FAIL.
          if (cnt_r == WINDOW_LAST) begin
            nxt_state_s = (diverge_r | div_s) ? ST_FAIL : ST_PASS;
          end else begin
            nxt_cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_PASS: nxt_state_s = ST_PASS;
        ST_FAIL: nxt_state_s = ST_FAIL;
        default: nxt_state_s = ST_IDLE;
      endcase
    end
    nxt_busy_s = (nxt_state_s == ST_SETTLE) || (nxt_state_s == ST_WATCH);
    nxt_done_s = (nxt_state_s == ST_PASS) || (nxt_state_s == ST_FAIL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diverge_r    <= 1'b0;
      fail_cycle_r <= CNT_ZERO;
      fail_addr1_r <= 32'h0000_0000;
      fail_addr2_r <= 32'h0000_0000;
      event_cnt_r  <= CNT_ZERO;
    end else begin
      state_r      <= nxt_state_s;
      cnt_r        <= nxt_cnt_s;
      busy_r       <= nxt_busy_s;
      done_r       <= nxt_done_s;
      diverge_r    <= nxt_diverge_s;
      fail_cycle_r <= nxt_fail_cycle_s;
      fail_addr1_r <= nxt_fail_addr1_s;
      fail_addr2_r <= nxt_fail_addr2_s;
      event_cnt_r  <= nxt_event_cnt_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diverge    = diverge_r;
  assign fail_cycle = fail_cycle_r;
  assign fail_addr1 = fail_addr1_r;
  assign fail_addr2 = fail_addr2_r;
  assign event_cnt  = event_cnt_r;

endmodule

// File: tb/tb_lb_diverge_monitor.sv
// Scoreboard bench for lb_diverge_monitor: expected verdicts are queued per observation and compared at done.
module tb_lb_diverge_monitor;

  localparam int S = 2;
  localparam int W = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic        lb_valid1, lb_valid2;
  logic [31:0] lb_addr1, lb_addr2, lb_data1, lb_data2;
  logic        busy, done, diverge;
  logic [7:0]  fail_cycle, event_cnt;
  logic [31:0] fail_addr1, fail_addr2;

  typedef struct {
    logic        diverge;
    logic [7:0]  fail_cycle;
    logic [31:0] fa1;
    logic [31:0] fa2;
    logic [7:0]  evt;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   error_cnt = 0;

  always #5 clk = ~clk;

  lb_diverge_monitor #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm),
    .lb_valid1(lb_valid1), .lb_valid2(lb_valid2),
    .lb_addr1(lb_addr1), .lb_addr2(lb_addr2),
    .lb_data1(lb_data1), .lb_data2(lb_data2),
    .busy(busy), .done(done), .diverge(diverge),
    .fail_cycle(fail_cycle), .fail_addr1(fail_addr1), .fail_addr2(fail_addr2),
    .event_cnt(event_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic d, input int fc, input logic [31:0] a1,
                                  input logic [31:0] a2, input int evt);
    exp_t e;
    e.diverge = d; e.fail_cycle = 8'(fc); e.fa1 = a1; e.fa2 = a2; e.evt = 8'(evt);
    return e;
  endfunction

  // k < 0 drives divergent garbage that the monitor must ignore outside WATCH
  task automatic drive_idx(input int c, input int k);
    lb_valid1 = 1'b1; lb_valid2 = 1'b1;
    lb_addr1 = 32'h64; lb_addr2 = 32'h64;
    lb_data1 = 32'h5;  lb_data2 = 32'h5;
    if (k < 0) begin
      lb_valid2 = 1'b0; lb_addr2 = 32'h99; lb_data2 = 32'h7;
    end else begin
      case (c)
        2: if (k == 3) lb_valid2 = 1'b0;
        3: if (k == 5 || k == 11) lb_addr2 = 32'h68;
        4: begin lb_data1 = 32'h1; lb_data2 = 32'h2; end
        7: if (k == 11) lb_valid1 = 1'b0;
        8: begin lb_valid1 = 1'b0; lb_valid2 = 1'b0; lb_addr2 = 32'h68; end
        9: if (k == 2) lb_addr2 = 32'h68;
        default: ;
      endcase
    end
  endtask

  task automatic check_cleared(input string tag, input logic exp_busy);
    check_val({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_diverge"}, 32'(diverge), 32'd0);
    check_val({tag, "_fail_cycle"}, 32'(fail_cycle), 32'd0);
    check_val({tag, "_fail_addr1"}, fail_addr1, 32'd0);
    check_val({tag, "_fail_addr2"}, fail_addr2, 32'd0);
    check_val({tag, "_event_cnt"}, 32'(event_cnt), 32'd0);
  endtask

  // Runs settle + window after arm was driven at the preceding negedge.
  task automatic window_body(input int c, input int first_div, input bit post_arm_chk);
    for (int i = 0; i < S + W; i++) begin
      @(negedge clk);
      arm = 1'b0;
      if (i == 0 && post_arm_chk) check_cleared("rearm", 1'b1);
      if (i == S) begin
        check_val("busy_in_window", 32'(busy), 32'd1);
        check_val("done_in_window", 32'(done), 32'd0);
      end
      if (first_div >= 0 && i - S - 1 == first_div) begin
        check_val("diverge_next_cycle", 32'(diverge), 32'd1);
        check_val("fail_cycle_next_cycle", 32'(fail_cycle), 32'(first_div));
      end
      drive_idx(c, i - S);
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_diverge"}, 32'(diverge), 32'(e.diverge));
    check_val({tag, "_fail_cycle"}, 32'(fail_cycle), 32'(e.fail_cycle));
    check_val({tag, "_fail_addr1"}, fail_addr1, e.fa1);
    check_val({tag, "_fail_addr2"}, fail_addr2, e.fa2);
    check_val({tag, "_event_cnt"}, 32'(event_cnt), 32'(e.evt));
  endtask

  task automatic wait_and_score(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!done && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_val({tag, "_done_latency"}, 32'(waited), 32'd0);
    check_val({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare_result(tag, e);
    end
  endtask

  task automatic run_case(input string tag, input int c, input int first_div, input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
    arm = 1'b1;
    drive_idx(c, -1);
    window_body(c, first_div, 1'b0);
    wait_and_score(tag);
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0; arm = 1'b0;
    drive_idx(0, -1);
    repeat (2) @(negedge clk);
    check_cleared("reset", 1'b0);
    reset_n = 1'b1;

    run_case("c1_equal", 1, -1, mk_exp(1'b0, 0, 32'h0, 32'h0, 0));
    run_case("c2_valid", 2, 3, mk_exp(1'b1, 3, 32'h64, 32'h64, 1));

    e = mk_exp(1'b1, 5, 32'h64, 32'h68, 2);
    run_case("c3_addr", 3, 5, e);
    // terminal state must ignore inputs and hold its verdict
    repeat (3) begin
      @(negedge clk);
      drive_idx(0, -1);
    end
    @(negedge clk);
    compare_result("c3_hold", e);

`ifdef LB_DIVERGE_DATA_CMP_EN
    run_case("c4_data", 4, 0, mk_exp(1'b1, 0, 32'h64, 32'h64, W));
`else
    run_case("c4_data", 4, -1, mk_exp(1'b0, 0, 32'h0, 32'h0, 0));
`endif
    run_case("c7_last", 7, 11, mk_exp(1'b1, 11, 32'h64, 32'h64, 1));
    run_case("c8_novalid", 8, -1, mk_exp(1'b0, 0, 32'h0, 32'h0, 0));

    // rearm mid-window after a divergence, then a clean window
    exp_q.push_back(mk_exp(1'b0, 0, 32'h0, 32'h0, 0));
    @(negedge clk);
    arm = 1'b1;
    drive_idx(9, -1);
    for (int i = 0; i <= S + 4; i++) begin
      @(negedge clk);
      arm = 1'b0;
      if (i == S + 4) begin
        check_val("c5_diverge_before_rearm", 32'(diverge), 32'd1);
        arm = 1'b1;
      end
      drive_idx(9, i - S);
    end
    window_body(1, -1, 1'b1);
    wait_and_score("c5_rearm");

    // reset in WATCH after a divergence
    @(negedge clk);
    arm = 1'b1;
    drive_idx(9, -1);
    for (int i = 0; i <= S + 4; i++) begin
      @(negedge clk);
      arm = 1'b0;
      if (i == S + 4) begin
        check_val("c6_diverge_before_reset", 32'(diverge), 32'd1);
        reset_n = 1'b0;
        arm = 1'b1;
      end
      drive_idx(9, i - S);
    end
    @(negedge clk);
    arm = 1'b0;
    check_cleared("c6_reset", 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_cleared("c6_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/lb_diverge_monitor.md
LB_DIVERGE_MONITOR -- requirements
Module: lb_diverge_monitor

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles ignored after arm, before comparison starts.
REQ-002 Parameter WINDOW_CYCLES, default 12: number of compared cycles; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of the cycle and event counters.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 arm  in  1  single-cycle pulse; starts or restarts an observation.
REQ-007 lb_valid1, lb_valid2  in  1 each  load-buffer-table valid bits from core copy 1 and core copy 2.
REQ-008 lb_addr1, lb_addr2  in  32 each  load-buffer-table addresses from the two copies.
REQ-009 lb_data1, lb_data2  in  32 each  load-buffer-table data from the two copies.
REQ-010 busy  out  1  high in SETTLE or WATCH.
REQ-011 done  out  1  high in PASS or FAIL.
REQ-012 diverge  out  1  sticky; high in FAIL.
REQ-013 fail_cycle  out  CNT_W  WATCH-cycle index of the first divergence.
REQ-014 fail_addr1, fail_addr2  out  32 each  lb_addr1 and lb_addr2 captured at the first divergence.
REQ-015 event_cnt  out  CNT_W  count of divergent WATCH cycles; saturates at all-ones.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, WATCH, PASS and FAIL.
REQ-017 IDLE transitions to SETTLE on arm; SETTLE_CYCLES=0 transitions directly to WATCH.
REQ-018 SETTLE lasts exactly SETTLE_CYCLES cycles, then transitions to WATCH with the cycle counter cleared.
REQ-019 A cycle is divergent when (lb_valid1 XOR lb_valid2), or when both valids are high and lb_addr1 != lb_addr2.
REQ-020 In WATCH the divergence condition is sampled every cycle; cycle index 0 is the first WATCH cycle.
REQ-021 The first divergent cycle captures fail_cycle, fail_addr1 and fail_addr2 and sets diverge, registered so all are visible the next cycle; the FSM stays in WATCH until the window expires.
REQ-022 Later divergent cycles increment event_cnt only; the capture registers hold their first values.
REQ-023 After exactly WINDOW_CYCLES WATCH cycles the FSM moves to FAIL if diverge is set, otherwise to PASS.
REQ-024 Divergence on the last window cycle is counted and can cause FAIL.
REQ-025 PASS and FAIL hold all outputs stable until the next arm or reset.
REQ-026 arm in any state restarts at SETTLE and clears diverge, event_cnt, fail_cycle and fail_addr1/2; arm has priority over a same-cycle divergence or window expiry.
REQ-027 Inputs are ignored in IDLE, SETTLE, PASS and FAIL.
REQ-028 The cycle counter does not wrap inside a window, because WINDOW_CYCLES is at most 2^CNT_W - 1.
REQ-029 event_cnt saturates at 2^CNT_W - 1.

Reset
REQ-030 While reset_n is 0 at a rising edge, the FSM goes to IDLE and the next-cycle outputs are: busy=0, done=0, diverge=0, fail_cycle=0, fail_addr1=0, fail_addr2=0, event_cnt=0.
REQ-031 Reset asserted mid-observation aborts it with no capture, and reset overrides arm.

Configuration
REQ-032 Macro LB_DIVERGE_DATA_CMP_EN, when defined, adds (both valids high and lb_data1 != lb_data2) as an extra divergence term.
REQ-033 Without LB_DIVERGE_DATA_CMP_EN, lb_data1/lb_data2 are unused, and a data-only mismatch is not a divergence.

Verification
REQ-034 Case 1: arm at cycle 0; both valid, addr 0x64 equal for the whole window -> PASS at cycle 2+12, diverge=0, event_cnt=0.
REQ-035 Case 2: lb_valid1=1, lb_valid2=0 at WATCH index 3 only -> FAIL, fail_cycle=3, event_cnt=1.
REQ-036 Case 3: addr1=0x64, addr2=0x68 at WATCH indices 5 and 11 -> fail_cycle=5, fail_addr1=0x64, fail_addr2=0x68, event_cnt=2.
REQ-037 Case 4: equal addr, data1=0x1, data2=0x2 -> FAIL with LB_DIVERGE_DATA_CMP_EN defined, PASS without it.
REQ-038 Case 5: divergence at WATCH index 2, then arm at index 4 -> all capture registers cleared, busy=1, new window passes.
REQ-039 Case 6: reset_n=0 during WATCH after a divergence -> IDLE the next cycle with all outputs 0; stays in IDLE without arm.
